// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects and extracts write-back data, then registers it for the register file.
// Latency: 1 cycle from MEM inputs to WB outputs; RFWr/WrDtAdr/WrDt/wb_valid are combinational from the stage flops.
// Backpressure: stall holds the stage, flush loads a bubble, and instret counts each instruction leaving WB.
module mem_wb_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        in_valid,
   input  logic        in_RegWrite,
   input  logic [1:0]  in_WDSel,
   input  logic [2:0]  in_DMType,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_alu,
   input  logic [31:0] in_mem,
   input  logic [31:0] in_pc,
   output logic        RFWr,
   output logic [4:0]  WrDtAdr,
   output logic [31:0] WrDt,
   output logic        wb_valid,
   output logic [63:0] instret
);

   // Write-data source encodings
   localparam logic [1:0] WD_ALU  = 2'b00;
   localparam logic [1:0] WD_MEM  = 2'b01;
   localparam logic [1:0] WD_PC4  = 2'b10;

   // Load types (funct3); anything else passes the raw word through
   localparam logic [2:0] DM_LB  = 3'b000;
   localparam logic [2:0] DM_LH  = 3'b001;
   localparam logic [2:0] DM_LW  = 3'b010;
   localparam logic [2:0] DM_LBU = 3'b100;
   localparam logic [2:0] DM_LHU = 3'b101;

   logic        valid_q,    valid_d;
   logic        regwrite_q, regwrite_d;
   logic [4:0]  rd_q,       rd_d;
   logic [31:0] data_q,     data_d;
   logic [63:0] instret_q,  instret_d;

   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_val;
   logic [31:0] wdata;
   logic        retire;

   // Pick the addressed byte and halfword out of the aligned memory word
   always_comb begin
      load_byte = in_mem[7:0];
      case (in_alu[1:0])
         2'd0:    load_byte = in_mem[7:0];
         2'd1:    load_byte = in_mem[15:8];
         2'd2:    load_byte = in_mem[23:16];
         default: load_byte = in_mem[31:24];
      endcase
      // Halfword selection ignores address bit 0
      load_half = in_alu[1] ? in_mem[31:16] : in_mem[15:0];
   end

   // Sign/zero extend according to load type; lw and reserved types pass the word unchanged
   always_comb begin
      load_val = in_mem;
      case (in_DMType)
         DM_LB:   load_val = {{24{load_byte[7]}}, load_byte};
         DM_LH:   load_val = {{16{load_half[15]}}, load_half};
         DM_LW:   load_val = in_mem;
         DM_LBU:  load_val = {24'd0, load_byte};
         DM_LHU:  load_val = {16'd0, load_half};
         default: load_val = in_mem;
      endcase
   end

   // Write-data mux ahead of the stage register
   always_comb begin
      wdata = 32'd0;
      case (in_WDSel)
         WD_ALU:  wdata = in_alu;
         WD_MEM:  wdata = load_val;
         WD_PC4:  wdata = in_pc + 32'd4;
         default: wdata = 32'd0;
      endcase
   end

   // Next-state: flush beats stall beats load; the occupant retires whenever it leaves WB
   always_comb begin
      valid_d    = valid_q;
      regwrite_d = regwrite_q;
      rd_d       = rd_q;
      data_d     = data_q;
      retire     = valid_q & (flush | ~stall);
      instret_d  = instret_q + (retire ? 64'd1 : 64'd0);
      if (flush) begin
         valid_d    = 1'b0;
         regwrite_d = 1'b0;
         rd_d       = 5'd0;
         data_d     = 32'd0;
      end else if (!stall) begin
         valid_d    = in_valid;
         regwrite_d = in_RegWrite;
         rd_d       = in_rd;
         data_d     = wdata;
      end
   end

   // Stage registers; reset discards any held instruction without counting it
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         rd_q       <= 5'd0;
         data_q     <= 32'd0;
         instret_q  <= 64'd0;
      end else begin
         valid_q    <= valid_d;
         regwrite_q <= regwrite_d;
         rd_q       <= rd_d;
         data_q     <= data_d;
         instret_q  <= instret_d;
      end
   end

   // Register-file write port; writes to x0 are suppressed
   always_comb begin
      RFWr     = valid_q & regwrite_q & (rd_q != 5'd0);
      WrDtAdr  = rd_q;
      WrDt     = data_q;
      wb_valid = valid_q;
      instret  = instret_q;
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, in_valid, in_RegWrite;
   logic [1:0]  in_WDSel;
   logic [2:0]  in_DMType;
   logic [4:0]  in_rd;
   logic [31:0] in_alu, in_mem, in_pc;
   logic        RFWr, wb_valid;
   logic [4:0]  WrDtAdr;
   logic [31:0] WrDt;
   logic [63:0] instret;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic        m_valid, m_rw;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic [63:0] m_instret;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_RegWrite(in_RegWrite), .in_WDSel(in_WDSel),
      .in_DMType(in_DMType), .in_rd(in_rd), .in_alu(in_alu), .in_mem(in_mem),
      .in_pc(in_pc), .RFWr(RFWr), .WrDtAdr(WrDtAdr), .WrDt(WrDt),
      .wb_valid(wb_valid), .instret(instret)
   );

   typedef struct {
      logic        stall, flush, vld, rw;
      logic [1:0]  wdsel;
      logic [2:0]  dm;
      logic [4:0]  rd;
      logic [31:0] alu, mem, pc;
      logic        e_rfwr;
      logic [4:0]  e_adr;
      logic [31:0] e_dt;
      logic        e_vld;
   } vec_t;

   localparam int NV = 20;
   vec_t vec [NV];

   // Load value computed arithmetically from the loaded word
   function automatic logic [31:0] ref_load(input logic [2:0] dm, input logic [31:0] alu, input logic [31:0] mem);
      logic [31:0] b, h;
      logic [1:0]  off;
      off = alu[1:0];
      b = (mem >> (8 * int'(off))) & 32'hFF;
      h = (mem >> (alu[1] ? 16 : 0)) & 32'hFFFF;
      case (dm)
         3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
         3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return mem;
      endcase
   endfunction

   function automatic logic [31:0] ref_wdata();
      case (in_WDSel)
         2'b00:   return in_alu;
         2'b01:   return ref_load(in_DMType, in_alu, in_mem);
         2'b10:   return in_pc + 32'd4;
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance the model by one edge using the current inputs, then clock the DUT
   task automatic step();
      if (rst) begin
         m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0; m_instret = 0;
      end else begin
         if (m_valid && (flush || !stall)) m_instret = m_instret + 64'd1;
         if (flush) begin
            m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0;
         end else if (!stall) begin
            m_valid = in_valid; m_rw = in_RegWrite; m_rd = in_rd; m_data = ref_wdata();
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".RFWr"},     {63'd0, RFWr},     {63'd0, m_valid && m_rw && (m_rd != 0)});
      chk({tag, ".WrDtAdr"},  {59'd0, WrDtAdr},  {59'd0, m_rd});
      chk({tag, ".WrDt"},     {32'd0, WrDt},     {32'd0, m_data});
      chk({tag, ".wb_valid"}, {63'd0, wb_valid}, {63'd0, m_valid});
      chk({tag, ".instret"},  instret,           m_instret);
   endtask

   task automatic drive(input logic v, input logic rw, input logic [1:0] wd, input logic [2:0] dm,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
      in_valid = v; in_RegWrite = rw; in_WDSel = wd; in_DMType = dm;
      in_rd = rd; in_alu = alu; in_mem = mem; in_pc = pc;
   endtask

   task automatic chk_outs(input string tag, input logic rf, input logic [4:0] adr, input logic [31:0] dt,
                           input logic vl, input logic [63:0] ir);
      chk({tag, ".RFWr"},     {63'd0, RFWr},     {63'd0, rf});
      chk({tag, ".WrDtAdr"},  {59'd0, WrDtAdr},  {59'd0, adr});
      chk({tag, ".WrDt"},     {32'd0, WrDt},     {32'd0, dt});
      chk({tag, ".wb_valid"}, {63'd0, wb_valid}, {63'd0, vl});
      chk({tag, ".instret"},  instret,           ir);
   endtask

   localparam logic [31:0] M = 32'h80FF7F01;

   initial begin
      //            stall flush vld rw wd     dm      rd     alu            mem   pc            rf adr    dt             vld
      vec[0]  = '{0, 0, 1, 1, 2'd1, 3'b000, 5'd5,  32'h103,      M, 32'h1000,     1, 5'd5,  32'hFFFFFF80, 1};
      vec[1]  = '{0, 0, 1, 1, 2'd1, 3'b101, 5'd6,  32'h102,      M, 32'h1000,     1, 5'd6,  32'h000080FF, 1};
      vec[2]  = '{0, 0, 1, 1, 2'd1, 3'b001, 5'd7,  32'h102,      M, 32'h1000,     1, 5'd7,  32'hFFFF80FF, 1};
      vec[3]  = '{0, 0, 1, 1, 2'd1, 3'b001, 5'd7,  32'h103,      M, 32'h1000,     1, 5'd7,  32'hFFFF80FF, 1};
      vec[4]  = '{0, 0, 1, 1, 2'd2, 3'b000, 5'd1,  32'h0,        M, 32'hFFFFFFFC, 1, 5'd1,  32'h00000000, 1};
      vec[5]  = '{0, 0, 1, 1, 2'd1, 3'b100, 5'd2,  32'h100,      M, 32'h1000,     1, 5'd2,  32'h00000001, 1};
      vec[6]  = '{0, 0, 1, 1, 2'd1, 3'b000, 5'd2,  32'h101,      M, 32'h1000,     1, 5'd2,  32'h0000007F, 1};
      vec[7]  = '{0, 0, 1, 1, 2'd1, 3'b000, 5'd2,  32'h102,      M, 32'h1000,     1, 5'd2,  32'hFFFFFFFF, 1};
      vec[8]  = '{0, 0, 1, 1, 2'd1, 3'b100, 5'd2,  32'h102,      M, 32'h1000,     1, 5'd2,  32'h000000FF, 1};
      vec[9]  = '{0, 0, 1, 1, 2'd1, 3'b101, 5'd2,  32'h100,      M, 32'h1000,     1, 5'd2,  32'h00007F01, 1};
      vec[10] = '{0, 0, 1, 1, 2'd1, 3'b010, 5'd2,  32'h103,      M, 32'h1000,     1, 5'd2,  32'h80FF7F01, 1};
      vec[11] = '{0, 0, 1, 1, 2'd1, 3'b011, 5'd2,  32'h101,      M, 32'h1000,     1, 5'd2,  32'h80FF7F01, 1};
      vec[12] = '{0, 0, 1, 1, 2'd1, 3'b111, 5'd2,  32'h102,      M, 32'h1000,     1, 5'd2,  32'h80FF7F01, 1};
      vec[13] = '{0, 0, 1, 1, 2'd0, 3'b000, 5'd3,  32'h12345678, M, 32'h1000,     1, 5'd3,  32'h12345678, 1};
      vec[14] = '{1, 0, 1, 1, 2'd0, 3'b000, 5'd4,  32'hDEADBEEF, M, 32'h1000,     1, 5'd3,  32'h12345678, 1};
      vec[15] = '{0, 0, 1, 1, 2'd3, 3'b000, 5'd4,  32'hDEADBEEF, M, 32'h1000,     1, 5'd4,  32'h00000000, 1};
      vec[16] = '{0, 0, 1, 1, 2'd0, 3'b000, 5'd0,  32'h55,       M, 32'h1000,     0, 5'd0,  32'h00000055, 1};
      vec[17] = '{0, 0, 0, 1, 2'd0, 3'b000, 5'd8,  32'h66,       M, 32'h1000,     0, 5'd8,  32'h00000066, 0};
      vec[18] = '{0, 0, 1, 0, 2'd0, 3'b000, 5'd9,  32'h77,       M, 32'h1000,     0, 5'd9,  32'h00000077, 1};
      vec[19] = '{0, 1, 1, 1, 2'd0, 3'b000, 5'd10, 32'h88,       M, 32'h1000,     0, 5'd0,  32'h00000000, 0};

      m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0; m_instret = 0;
      rst = 1; stall = 0; flush = 0;
      drive(1, 1, 2'd0, 3'b000, 5'd3, 32'h1234, M, 32'h0);

      // reset state
      step();
      step();
      chk_outs("reset", 0, 5'd0, 32'd0, 0, 64'd0);
      rst = 0;

      // table-driven vectors
      for (int i = 0; i < NV; i++) begin
         stall = vec[i].stall; flush = vec[i].flush;
         drive(vec[i].vld, vec[i].rw, vec[i].wdsel, vec[i].dm, vec[i].rd, vec[i].alu, vec[i].mem, vec[i].pc);
         step();
         chk($sformatf("vec%0d.RFWr", i),     {63'd0, RFWr},     {63'd0, vec[i].e_rfwr});
         chk($sformatf("vec%0d.WrDtAdr", i),  {59'd0, WrDtAdr},  {59'd0, vec[i].e_adr});
         chk($sformatf("vec%0d.WrDt", i),     {32'd0, WrDt},     {32'd0, vec[i].e_dt});
         chk($sformatf("vec%0d.wb_valid", i), {63'd0, wb_valid}, {63'd0, vec[i].e_vld});
         chk($sformatf("vec%0d.instret", i),  instret,           m_instret);
      end
      flush = 0;

      // stall held 3 cycles, then release, then stall+flush
      rst = 1; step(); rst = 0;
      drive(1, 1, 2'd0, 3'b000, 5'd9, 32'hAAAA5555, M, 32'h0);
      step();
      chk_outs("stall.load", 1, 5'd9, 32'hAAAA5555, 1, 64'd0);
      stall = 1;
      drive(1, 1, 2'd0, 3'b000, 5'd12, 32'h11111111, M, 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk_outs($sformatf("stall.hold%0d", k), 1, 5'd9, 32'hAAAA5555, 1, 64'd0);
      end
      stall = 0;
      drive(0, 0, 2'd0, 3'b000, 5'd0, 32'h0, M, 32'h0);
      step();
      chk_outs("stall.release", 0, 5'd0, 32'd0, 0, 64'd1);
      drive(1, 1, 2'd0, 3'b000, 5'd11, 32'hCAFE0000, M, 32'h0);
      step();
      chk_outs("sf.load", 1, 5'd11, 32'hCAFE0000, 1, 64'd1);
      stall = 1; flush = 1;
      step();
      chk_outs("sf.bubble", 0, 5'd0, 32'd0, 0, 64'd2);
      stall = 0; flush = 0;

      // write to x0: no RFWr, still retires on next non-stall edge
      drive(1, 1, 2'd0, 3'b000, 5'd0, 32'h42, M, 32'h0);
      step();
      chk_outs("x0.load", 0, 5'd0, 32'h42, 1, 64'd2);
      drive(0, 0, 2'd0, 3'b000, 5'd0, 32'h0, M, 32'h0);
      step();
      chk_outs("x0.retire", 0, 5'd0, 32'h0, 0, 64'd3);

      // reset mid-stall with instret = 7
      rst = 1; step(); rst = 0;
      drive(1, 1, 2'd0, 3'b000, 5'd13, 32'h77777777, M, 32'h0);
      for (int k = 0; k < 8; k++) step();
      stall = 1;
      step();
      chk_outs("rststall.pre", 1, 5'd13, 32'h77777777, 1, 64'd7);
      rst = 1;
      step();
      chk_outs("rststall.post", 0, 5'd0, 32'd0, 0, 64'd0);
      rst = 0; stall = 0;

      // randomized run against the reference model
      for (int c = 0; c < 400; c++) begin
         rst   = ($urandom_range(0, 49) == 0);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 9) == 0);
         drive($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
               5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
         step();
         chk_model($sformatf("rand%0d", c));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
